// File: rtl/cam_pkg.sv
// Shared types and constants for the camera line-capture front end.
// Imported by the run counter, the bus interface and the capture top.
package cam_pkg;

    typedef enum logic [1:0] {
        ST_VBLANK = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2
    } cam_state_e;

    localparam int CAM_DW = 6;
    localparam int EBR_AW = 9;
    localparam int EBR_DW = 8;

    localparam logic [CAM_DW-1:0] BLANK_CODE_DEF = 6'h00;

    // Camera samples are narrower than the EBR word; the upper bits are zero.
    function automatic logic [EBR_DW-1:0] pad_pixel(input logic [CAM_DW-1:0] px);
        return {{(EBR_DW - CAM_DW){1'b0}}, px};
    endfunction

endpackage

// File: rtl/cam_line_capture_if.sv
// Camera-side inputs plus EBR write port and line-report outputs of the capture stage.
// The slave modport is the capture block; the master modport is the camera/reader side.
interface cam_line_capture_if;
    import cam_pkg::*;

    logic [CAM_DW-1:0] camD;
    logic              enable;
    logic [EBR_AW-1:0] ebrWAddr;
    logic [EBR_DW-1:0] ebrWData;
    logic              ebrWE;
    logic              hBlankStrobe;
    logic              vBlankStrobe;
    logic              lineReady;
    logic              lineBank;
    logic [EBR_AW-1:0] lineLen;
    logic              lineOvf;
    logic              blankCounterReset;

    modport master (
        output camD,
        output enable,
        input  ebrWAddr,
        input  ebrWData,
        input  ebrWE,
        input  hBlankStrobe,
        input  vBlankStrobe,
        input  lineReady,
        input  lineBank,
        input  lineLen,
        input  lineOvf,
        input  blankCounterReset
    );

    modport slave (
        input  camD,
        input  enable,
        output ebrWAddr,
        output ebrWData,
        output ebrWE,
        output hBlankStrobe,
        output vBlankStrobe,
        output lineReady,
        output lineBank,
        output lineLen,
        output lineOvf,
        output blankCounterReset
    );

endinterface

// File: rtl/cam_blank_run_counter.sv
// Saturating counter of consecutive blank samples with single-cycle threshold hits.
// The hit outputs are combinational on the current sample so the FSM can register its reaction.
module cam_blank_run_counter
    import cam_pkg::*;
#(
    parameter logic [CAM_DW-1:0] BLANK_CODE = BLANK_CODE_DEF,
    parameter int                HBLANK_MIN = 8,
    parameter int                VBLANK_MIN = 512
) (
    input  logic              pclk,
    input  logic              rstn,
    input  logic [CAM_DW-1:0] sample,
    output logic              is_blank,
    output logic              run_start,
    output logic              hblank_hit,
    output logic              vblank_hit
);

    localparam int               RUN_W   = $clog2(VBLANK_MIN + 1);
    localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(VBLANK_MIN);
    localparam logic [RUN_W-1:0] H_LAST  = RUN_W'(HBLANK_MIN - 1);
    localparam logic [RUN_W-1:0] V_LAST  = RUN_W'(VBLANK_MIN - 1);

    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;

    always_comb begin
        is_blank = (sample == BLANK_CODE);
        run_d    = '0;
        if (is_blank) begin
            run_d = (run_q == RUN_SAT) ? run_q : run_q + RUN_W'(1);
        end
    end

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

    // Saturation keeps each threshold hit to exactly one sample per run.
    assign run_start  = is_blank && (run_q == '0);
    assign hblank_hit = is_blank && (run_q == H_LAST);
    assign vblank_hit = is_blank && (run_q == V_LAST);

endmodule

// File: rtl/cam_line_capture.sv
// Camera line capture: finds line/frame blanking, writes active pixels into a
// ping-pong pair of 256-byte EBR banks and announces each finished line.
module cam_line_capture
    import cam_pkg::*;
#(
    parameter logic [CAM_DW-1:0] BLANK_CODE = BLANK_CODE_DEF,
    parameter int                HBLANK_MIN = 8,
    parameter int                VBLANK_MIN = 512,
    parameter int                LINE_MAX   = 256
) (
    input  logic               pclk,
    input  logic               rstn,
    cam_line_capture_if.slave  cam
);

    localparam int                IDX_W      = EBR_AW - 1;
    localparam logic [EBR_AW-1:0] LINE_MAX_C = EBR_AW'(LINE_MAX);

    cam_state_e        state_q, state_d;
    logic              bank_q, bank_d;
    logic [EBR_AW-1:0] count_q, count_d;
    logic [EBR_AW-1:0] len_mark_q, len_mark_d;
    logic              ovf_q, ovf_d;

    logic [EBR_AW-1:0] waddr_q, waddr_d;
    logic [EBR_DW-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              hstrobe_q, hstrobe_d;
    logic              vstrobe_q, vstrobe_d;
    logic              line_ready_q, line_ready_d;
    logic              line_bank_q, line_bank_d;
    logic [EBR_AW-1:0] line_len_q, line_len_d;
    logic              line_ovf_q, line_ovf_d;
    logic              cnt_clear_q, cnt_clear_d;

    logic is_blank;
    logic run_start;
    logic hblank_hit;
    logic vblank_hit;
    logic line_start;

    cam_blank_run_counter #(
        .BLANK_CODE (BLANK_CODE),
        .HBLANK_MIN (HBLANK_MIN),
        .VBLANK_MIN (VBLANK_MIN)
    ) u_run (
        .pclk       (pclk),
        .rstn       (rstn),
        .sample     (cam.camD),
        .is_blank   (is_blank),
        .run_start  (run_start),
        .hblank_hit (hblank_hit),
        .vblank_hit (vblank_hit)
    );

    // enable only gates the start of a frame; lines inside a frame always restart.
    assign line_start = !is_blank &&
                        ((state_q == ST_HBLANK) ||
                         ((state_q == ST_VBLANK) && cam.enable));

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_VBLANK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_VBLANK: begin
                if (line_start) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (hblank_hit) begin
                    state_d = ST_HBLANK;
                end
            end
            ST_HBLANK: begin
                if (line_start) begin
                    state_d = ST_ACTIVE;
                end else if (vblank_hit) begin
                    state_d = ST_VBLANK;
                end
            end
            default: begin
                state_d = ST_VBLANK;
            end
        endcase
    end

    always_comb begin
        bank_d       = bank_q;
        count_d      = count_q;
        len_mark_d   = len_mark_q;
        ovf_d        = ovf_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        we_d         = 1'b0;
        hstrobe_d    = 1'b0;
        vstrobe_d    = 1'b0;
        line_ready_d = 1'b0;
        line_bank_d  = line_bank_q;
        line_len_d   = line_len_q;
        line_ovf_d   = line_ovf_q;
        cnt_clear_d  = !is_blank;

        if (line_start) begin
            we_d    = 1'b1;
            waddr_d = {bank_q, {IDX_W{1'b0}}};
            wdata_d = pad_pixel(cam.camD);
            count_d = EBR_AW'(1);
            ovf_d   = 1'b0;
        end else if (state_q == ST_ACTIVE) begin
            if (hblank_hit) begin
                // The sample completing the run is not stored; the line is reported from lenMark.
                hstrobe_d    = 1'b1;
                line_ready_d = 1'b1;
                line_bank_d  = bank_q;
                line_len_d   = len_mark_q;
                line_ovf_d   = ovf_q;
                bank_d       = !bank_q;
            end else begin
                if (run_start) begin
                    len_mark_d = count_q;
                end
                if (count_q < LINE_MAX_C) begin
                    we_d    = 1'b1;
                    waddr_d = {bank_q, count_q[IDX_W-1:0]};
                    wdata_d = pad_pixel(cam.camD);
                    count_d = count_q + EBR_AW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end else if ((state_q == ST_HBLANK) && vblank_hit) begin
            vstrobe_d = 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            bank_q       <= 1'b0;
            count_q      <= '0;
            len_mark_q   <= '0;
            ovf_q        <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            hstrobe_q    <= 1'b0;
            vstrobe_q    <= 1'b0;
            line_ready_q <= 1'b0;
            line_bank_q  <= 1'b0;
            line_len_q   <= '0;
            line_ovf_q   <= 1'b0;
            cnt_clear_q  <= 1'b0;
        end else begin
            bank_q       <= bank_d;
            count_q      <= count_d;
            len_mark_q   <= len_mark_d;
            ovf_q        <= ovf_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            hstrobe_q    <= hstrobe_d;
            vstrobe_q    <= vstrobe_d;
            line_ready_q <= line_ready_d;
            line_bank_q  <= line_bank_d;
            line_len_q   <= line_len_d;
            line_ovf_q   <= line_ovf_d;
            cnt_clear_q  <= cnt_clear_d;
        end
    end

    assign cam.ebrWAddr          = waddr_q;
    assign cam.ebrWData          = wdata_q;
    assign cam.ebrWE             = we_q;
    assign cam.hBlankStrobe      = hstrobe_q;
    assign cam.vBlankStrobe      = vstrobe_q;
    assign cam.lineReady         = line_ready_q;
    assign cam.lineBank          = line_bank_q;
    assign cam.lineLen           = line_len_q;
    assign cam.lineOvf           = line_ovf_q;
    assign cam.blankCounterReset = cnt_clear_q;

endmodule

// File: tb/tb_cam_line_capture.sv
// Bench for cam_line_capture: streams are built line-by-line and gap-by-gap, and each
// sample carries the outputs its line/gap position implies one pclk later.
module tb_cam_line_capture;
    import cam_pkg::*;

    localparam int HB = 4;
    localparam int VB = 16;
    localparam int LM = 256;

    typedef struct {
        logic [5:0] d;
        logic       en;
        logic       we;
        logic [8:0] addr;
        logic [7:0] data;
        logic       hs;
        logic       vs;
        logic       lr;
        logic       bank;
        logic [8:0] len;
        logic       ovf;
    } step_t;

    logic pclk = 1'b0;
    logic rstn;

    always #5 pclk = ~pclk;

    cam_line_capture_if cam ();

    cam_line_capture #(
        .BLANK_CODE (6'h00),
        .HBLANK_MIN (HB),
        .VBLANK_MIN (VB),
        .LINE_MAX   (LM)
    ) dut (
        .pclk (pclk),
        .rstn (rstn),
        .cam  (cam)
    );

    int checks   = 0;
    int failures = 0;

    step_t      steps[$];
    logic [5:0] pix[$];
    bit         mBank;
    int         mLen;
    logic [8:0] heldLen;
    logic       heldOvf;

    logic [8:0] obsLen[$];
    logic       obsBank[$];
    logic       obsOvf[$];
    logic [8:0] obsStart[$];
    int         obsVs;

    int expB[9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
    int expL[9] = '{10, 5, 5, 5, 256, 6, 253, 254, 7};
    int expO[9] = '{0, 0, 0, 0, 1, 0, 0, 1, 0};

    int nStart;
    int nRep;
    int nLines;
    int lineLenPick;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic step_t mkStep(input logic [5:0] d, input logic en);
        step_t s;
        s.d    = d;
        s.en   = en;
        s.we   = 1'b0;
        s.addr = '0;
        s.data = '0;
        s.hs   = 1'b0;
        s.vs   = 1'b0;
        s.lr   = 1'b0;
        s.bank = 1'b0;
        s.len  = '0;
        s.ovf  = 1'b0;
        return s;
    endfunction

    function automatic logic [5:0] nonBlank();
        return 6'($urandom_range(1, 63));
    endfunction

    // Samples in frame blanking (or ignored while disabled) produce no activity.
    task automatic addIdle(input int n, input logic [5:0] val, input logic en);
        for (int k = 0; k < n; k++) steps.push_back(mkStep(val, en));
    endtask

    // Every sample of a line is stored at its position while it fits in the bank.
    task automatic addLine(input logic firstEn);
        step_t s;
        for (int j = 0; j < pix.size(); j++) begin
            s = mkStep(pix[j], (j == 0) ? firstEn : 1'($urandom_range(0, 1)));
            if (j < LM) begin
                s.we   = 1'b1;
                s.addr = {mBank, 8'(j)};
                s.data = {2'b00, pix[j]};
            end
            steps.push_back(s);
        end
        mLen = pix.size();
    endtask

    // The first HB-1 gap blanks are stored as line bytes, the HB-th reports the line,
    // and the VB-th blank of the gap enters frame blanking.
    task automatic addGap(input int n);
        step_t s;
        int    j;
        for (int k = 1; k <= n; k++) begin
            s = mkStep(6'h00, 1'($urandom_range(0, 1)));
            if (k < HB) begin
                j = mLen + k - 1;
                if (j < LM) begin
                    s.we   = 1'b1;
                    s.addr = {mBank, 8'(j)};
                    s.data = 8'h00;
                end
            end else if (k == HB) begin
                s.hs   = 1'b1;
                s.lr   = 1'b1;
                s.bank = mBank;
                s.len  = 9'((mLen > LM) ? LM : mLen);
                s.ovf  = (mLen + HB - 1) > LM;
                mBank  = !mBank;
            end
            if (k == VB) s.vs = 1'b1;
            steps.push_back(s);
        end
    endtask

    task automatic buildRamp(input int n, input int base);
        pix.delete();
        for (int j = 0; j < n; j++) pix.push_back(6'(((base + j) % 63) + 1));
    endtask

    task automatic buildRandomLine(input int n);
        int r;
        pix.delete();
        pix.push_back(nonBlank());
        while (pix.size() < n - 1) begin
            if (($urandom_range(0, 7) == 0) && (pix[pix.size() - 1] != 6'h00)) begin
                r = $urandom_range(1, HB - 1);
                for (int k = 0; k < r && pix.size() < n - 1; k++) pix.push_back(6'h00);
            end else begin
                pix.push_back(nonBlank());
            end
        end
        if (n > 1) pix.push_back(nonBlank());
    endtask

    task automatic applyStimulus();
        step_t s;
        for (int i = 0; i < steps.size(); i++) begin
            s = steps[i];
            @(negedge pclk);
            cam.camD   = s.d;
            cam.enable = s.en;
            @(posedge pclk);
            #1;
            checkOutput($sformatf("ebrWE@%0d", i), 32'(cam.ebrWE), 32'(s.we));
            if (s.we) begin
                checkOutput($sformatf("ebrWAddr@%0d", i), 32'(cam.ebrWAddr), 32'(s.addr));
                checkOutput($sformatf("ebrWData@%0d", i), 32'(cam.ebrWData), 32'(s.data));
            end
            checkOutput($sformatf("hBlankStrobe@%0d", i), 32'(cam.hBlankStrobe), 32'(s.hs));
            checkOutput($sformatf("vBlankStrobe@%0d", i), 32'(cam.vBlankStrobe), 32'(s.vs));
            checkOutput($sformatf("lineReady@%0d", i), 32'(cam.lineReady), 32'(s.lr));
            checkOutput($sformatf("blankCounterReset@%0d", i), 32'(cam.blankCounterReset),
                        32'(s.d != 6'h00));
            if (s.lr) begin
                checkOutput($sformatf("lineBank@%0d", i), 32'(cam.lineBank), 32'(s.bank));
                heldLen = s.len;
                heldOvf = s.ovf;
            end
            checkOutput($sformatf("lineLen@%0d", i), 32'(cam.lineLen), 32'(heldLen));
            checkOutput($sformatf("lineOvf@%0d", i), 32'(cam.lineOvf), 32'(heldOvf));
            if (cam.lineReady) begin
                obsLen.push_back(cam.lineLen);
                obsBank.push_back(cam.lineBank);
                obsOvf.push_back(cam.lineOvf);
            end
            if (cam.ebrWE && (cam.ebrWAddr[7:0] == 8'h00)) obsStart.push_back(cam.ebrWAddr);
            if (cam.vBlankStrobe) obsVs++;
        end
        steps.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_wrport"}, 32'({cam.ebrWAddr, cam.ebrWData, cam.ebrWE}), 32'h0);
        checkOutput({tag, "_report"}, 32'({cam.hBlankStrobe, cam.vBlankStrobe, cam.lineReady,
                    cam.lineBank, cam.lineLen, cam.lineOvf, cam.blankCounterReset}), 32'h0);
    endtask

    initial begin
        rstn       = 1'b0;
        cam.camD   = 6'h00;
        cam.enable = 1'b0;
        mBank      = 1'b0;
        mLen       = 0;
        heldLen    = '0;
        heldOvf    = 1'b0;
        obsVs      = 0;
        #12;
        checkAllZero("resetState");
        @(negedge pclk);
        rstn = 1'b1;
        $display("[TB] reset released");

        addIdle(2, 6'h00, 1'b1);
        buildRamp(10, 0);
        addLine(1'b1);
        addGap(VB);
        applyStimulus();

        obsVs = 0;
        pix = {6'd21, 6'd22, 6'd23, 6'd24, 6'd25};
        addLine(1'b1);
        addGap(HB);
        addLine(1'($urandom_range(0, 1)));
        addGap(HB);
        addLine(1'($urandom_range(0, 1)));
        addGap(VB);
        applyStimulus();
        checkOutput("vBlankOncePerFrame", 32'(obsVs), 32'd1);

        for (int k = 0; k < 5; k++) addIdle(1, 6'(40 + k), 1'b0);
        addIdle(2, 6'h00, 1'b1);
        buildRamp(300, 3);
        addLine(1'b1);
        addGap(HB);
        buildRamp(6, 17);
        addLine(1'($urandom_range(0, 1)));
        addGap(6);
        buildRamp(253, 9);
        addLine(1'($urandom_range(0, 1)));
        addGap(HB);
        buildRamp(254, 30);
        addLine(1'($urandom_range(0, 1)));
        addGap(VB);
        applyStimulus();

        pix = {6'd3, 6'd7, 6'd0, 6'd0, 6'd0, 6'd9, 6'd2};
        addLine(1'b1);
        addGap(20);
        applyStimulus();

        checkOutput("reportCount", 32'(obsLen.size()), 32'd9);
        for (int r = 0; r < 9; r++) begin
            if (r < obsLen.size()) begin
                checkOutput($sformatf("report%0d_bank", r), 32'(obsBank[r]), 32'(expB[r]));
                checkOutput($sformatf("report%0d_len", r), 32'(obsLen[r]), 32'(expL[r]));
                checkOutput($sformatf("report%0d_ovf", r), 32'(obsOvf[r]), 32'(expO[r]));
            end
        end
        checkOutput("firstLineStart", 32'((obsStart.size() > 0) ? obsStart[0] : 9'h1FF), 32'h000);
        checkOutput("secondLineStart", 32'((obsStart.size() > 1) ? obsStart[1] : 9'h1FF), 32'h100);

        for (int f = 0; f < 3; f++) begin
            addIdle($urandom_range(1, 3), 6'h00, 1'b1);
            nLines = $urandom_range(1, 3);
            for (int l = 0; l < nLines; l++) begin
                lineLenPick = ($urandom_range(0, 4) == 0) ? $urandom_range(250, 262)
                                                          : $urandom_range(1, 30);
                buildRandomLine(lineLenPick);
                addLine((l == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
                addGap((l == nLines - 1) ? $urandom_range(VB, VB + 8) : $urandom_range(HB, VB - 1));
            end
        end
        applyStimulus();
        $display("[TB] random frames done");

        addIdle(1, 6'h00, 1'b1);
        buildRamp(20, 50);
        addLine(1'b1);
        applyStimulus();
        #1;
        rstn = 1'b0;
        #1;
        checkAllZero("asyncReset");
        @(negedge pclk);
        cam.camD = 6'h00;
        @(negedge pclk);
        rstn    = 1'b1;
        mBank   = 1'b0;
        mLen    = 0;
        heldLen = '0;
        heldOvf = 1'b0;
        nStart  = obsStart.size();
        nRep    = obsLen.size();

        addIdle(2, 6'h00, 1'b1);
        buildRamp(6, 5);
        addLine(1'b1);
        addGap(VB);
        applyStimulus();
        checkOutput("startAfterReset",
                    32'((obsStart.size() > nStart) ? obsStart[nStart] : 9'h1FF), 32'h000);
        checkOutput("reportsAfterReset", 32'(obsLen.size() - nRep), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
